instruction_compressor: RTL
===========================

// Module: instruction_compressor
// PURPOSE
//  Encoder counterpart of the token-table decompressor. Consumes a stream of WIDTH-bit
//  instructions and replaces each consecutive pair that matches a programmed table entry
//  with one token word {OPcode, 0.., index}. Unmatched instructions pass through raw.
//  Sits in the offline/boot image path that feeds the compressed program memory.
// PARAMETERS
//  WIDTH        32       instruction / token width
//  OPcode       4'b1111  token marker placed in the top encodeLength bits
//  encodeLength 4        width of the token marker field
//  NUM_PAIRS    16       number of instruction pairs in the table (power of 2, >=2)
//  IDXW         $clog2(NUM_PAIRS)  index width; token low IDXW bits = pair index
// PORTS
//  clk           in   1          clock, all state on rising edge
//  reset         in   1          synchronous, active-high reset
//  wme           in   1          table write enable
//  WriteAddr     in   IDXW+1     word address; pair k = words 2k (first), 2k+1 (second)
//  WriteData     in   WIDTH      table write data
//  in_valid      in   1          InInstr valid
//  in_ready      out  1          block accepts InInstr this cycle
//  InInstr       in   WIDTH      raw input instruction
//  flush         in   1          end of stream: drain a held single instruction
//  out_valid     out  1          OutWord valid
//  out_ready     in   1          downstream accepts OutWord
//  OutWord       out  WIDTH      raw instruction or token
//  out_is_token  out  1          OutWord is a token
//  table_busy    out  1          1 when FSM not IDLE; table writes are dropped
//  collision_err out  1          sticky: a raw input had top bits == OPcode
// BEHAVIOUR
//  Reset: FSM=IDLE, out_valid=0, OutWord=0, out_is_token=0, collision_err=0, all
//   pair-valid bits=0 (table data unchanged); in_ready=0 during the reset cycle.
//  Table: write to odd addr 2k+1 sets pair_valid[k]; write to even addr 2k clears it.
//   Writes applied only when FSM==IDLE; otherwise dropped silently.
//  in_ready = (state==IDLE || state==HELD) && !reset. Transfer = in_valid && in_ready.
//  Output handshake: OutWord/out_is_token stable while out_valid && !out_ready;
//   out_valid drops the cycle after out_valid && out_ready unless reloaded.
//  States:
//   IDLE:  transfer -> first<=InInstr, HELD. flush ignored.
//   HELD:  transfer -> second<=InInstr, idx<=0, SEARCH (transfer wins over flush);
//          else flush -> OutWord<=first raw, OUT_LAST.
//   SEARCH: one compare/cycle: pair_valid[idx] && tbl[2idx]==first && tbl[2idx+1]==second
//          match -> OutWord<={OPcode,zeros,idx}, out_is_token=1, OUT_TOKEN;
//          no match && idx==NUM_PAIRS-1 -> OutWord<=first, out_is_token=0, OUT_RAW;
//          else idx<=idx+1. Lowest matching index wins.
//   OUT_TOKEN: out_ready -> IDLE.  OUT_RAW: out_ready -> first<=second, HELD (greedy).
//   OUT_LAST:  out_ready -> IDLE.
//  Latency: match at index k -> out_valid asserted k+1 cycles after second transfer;
//   full miss -> NUM_PAIRS cycles.
//  collision_err sets on any transfer with InInstr[WIDTH-1:WIDTH-encodeLength]==OPcode;
//   data still processed normally; cleared only by reset.
//  Reset mid-operation: held/pending words discarded, no output emitted.
// TESTING
//  Program pair 3 = (0x00A00093,0x00108113); send those two -> one token 0xF0000003, is_token=1.
//  Send A,B with no match (16 entries valid) -> A raw after 16 cycles, B held; flush -> B raw.
//  Send A,X,Y where (X,Y) is pair 5 -> A raw, then token 0xF0000005 (greedy re-pairing).
//  Hold out_ready=0 for 10 cycles on a token -> OutWord stable, in_ready=0, no input lost.
//  Write table while SEARCH -> table_busy=1, write dropped; input 0xF0001234 -> collision_err=1.
//  Assert reset during SEARCH -> next cycle out_valid=0, state IDLE, pair_valid all 0.

Source files
------------

// File: rtl/instruction_compressor.sv
// Pair-matching instruction compressor: folds table-matched consecutive pairs into token words.
// Latency k+1 cycles for a match at index k, NUM_PAIRS on a miss; input stalls while searching or outputting.
module instruction_compressor #(
   parameter int                      WIDTH        = 32,
   parameter int                      encodeLength = 4,
   parameter logic [encodeLength-1:0] OPcode       = 4'b1111,
   parameter int                      NUM_PAIRS    = 16,
   parameter int                      IDXW         = $clog2(NUM_PAIRS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wme,
   input  logic [IDXW:0]    WriteAddr,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] InInstr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] OutWord,
   output logic             out_is_token,
   output logic             table_busy,
   output logic             collision_err
);

   typedef enum logic [2:0] {IDLE, HELD, SEARCH, OUT_TOKEN, OUT_RAW, OUT_LAST} state_t;

   state_t                 state;
   logic [WIDTH-1:0]       tbl [2*NUM_PAIRS];
   logic [NUM_PAIRS-1:0]   pair_valid;
   logic [WIDTH-1:0]       first;
   logic [WIDTH-1:0]       second;
   logic [IDXW-1:0]        idx;
   logic                   xfer;
   logic                   tbl_we;
   logic                   hit;
   logic [WIDTH-1:0]       token;

   assign in_ready   = (state == IDLE || state == HELD) && !reset;
   assign xfer       = in_valid && in_ready;
   assign table_busy = (state != IDLE);
   assign tbl_we     = wme && (state == IDLE) && !reset;
   assign hit        = pair_valid[idx] && (tbl[{idx, 1'b0}] == first) && (tbl[{idx, 1'b1}] == second);

   always_comb begin
      token                            = '0;
      token[WIDTH-1 -: encodeLength]   = OPcode;
      token[IDXW-1:0]                  = idx;
   end

   // Table contents survive reset; only the per-pair valid bits are cleared.
   always_ff @(posedge clk) begin
      if (tbl_we)
         tbl[WriteAddr] <= WriteData;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         out_valid     <= 1'b0;
         OutWord       <= '0;
         out_is_token  <= 1'b0;
         collision_err <= 1'b0;
         pair_valid    <= '0;
         idx           <= '0;
         first         <= '0;
         second        <= '0;
      end else begin
         // Writing the second word of a pair arms it; writing the first word disarms it.
         if (tbl_we)
            pair_valid[WriteAddr[IDXW:1]] <= WriteAddr[0];
         if (xfer && InInstr[WIDTH-1 -: encodeLength] == OPcode)
            collision_err <= 1'b1;
         case (state)
            IDLE: begin
               if (xfer) begin
                  first <= InInstr;
                  state <= HELD;
               end
            end
            HELD: begin
               if (xfer) begin
                  second <= InInstr;
                  idx    <= '0;
                  state  <= SEARCH;
               end else if (flush) begin
                  OutWord      <= first;
                  out_is_token <= 1'b0;
                  out_valid    <= 1'b1;
                  state        <= OUT_LAST;
               end
            end
            SEARCH: begin
               if (hit) begin
                  OutWord      <= token;
                  out_is_token <= 1'b1;
                  out_valid    <= 1'b1;
                  state        <= OUT_TOKEN;
               end else if (idx == IDXW'(NUM_PAIRS - 1)) begin
                  OutWord      <= first;
                  out_is_token <= 1'b0;
                  out_valid    <= 1'b1;
                  state        <= OUT_RAW;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            OUT_TOKEN, OUT_LAST: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            OUT_RAW: begin
               // Greedy: the unmatched second word becomes the first of the next candidate pair.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  first     <= second;
                  state     <= HELD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
